// File: rtl/vga_pixel_fetch.sv
// Framebuffer scan-out fetcher: reads the frame linearly over Wishbone classic
// into a pixel FIFO and pops one RGB pixel per displayed-pixel request.
module vga_pixel_fetch #(
    parameter int unsigned HDISP      = 800,
    parameter int unsigned VDISP      = 480,
    parameter int unsigned FIFO_DEPTH = 256,
    parameter logic [31:0] BASE_ADDR  = 32'h0000_0000
) (
    input  logic                          pixel_clk,
    input  logic                          pixel_rst,
    input  logic                          frame_start,
    input  logic                          pixel_req,
    output logic [23:0]                   pixel_rgb,
    output logic                          underflow,
    output logic                          wb_cyc,
    output logic                          wb_stb,
    output logic [31:0]                   wb_adr,
    input  logic [31:0]                   wb_dat_i,
    input  logic                          wb_ack,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

    localparam int unsigned NPIX = HDISP * VDISP;
    localparam int unsigned IW   = $clog2(NPIX + 1);
    localparam int unsigned AW   = $clog2(FIFO_DEPTH);
    localparam int unsigned LW   = AW + 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_DONE
    } state_t;

    state_t          r_state;
    state_t          w_next;
    logic [IW-1:0]   r_index;
    logic [31:0]     r_adr;
    logic [23:0]     r_mem [FIFO_DEPTH];
    logic [AW-1:0]   r_wptr;
    logic [AW-1:0]   r_rptr;
    logic [LW-1:0]   r_level;
    logic [23:0]     r_rgb;
    logic            r_underflow;

    logic            w_room;
    logic            w_more;
    logic            w_last;
    logic            w_issue;
    logic            w_push;
    logic            w_pop;
    logic            w_unused;

    assign w_room   = r_level < LW'(FIFO_DEPTH);
    assign w_more   = r_index < IW'(NPIX);
    assign w_last   = r_index == IW'(NPIX - 1);
    // frame_start discards any ack and any pop arriving in the same cycle
    assign w_push   = (r_state == S_REQ) && wb_ack && !frame_start;
    assign w_pop    = pixel_req && (r_level != '0) && !frame_start;
    assign w_issue  = (r_state == S_IDLE) && (w_next == S_REQ);
    assign w_unused = ^wb_dat_i[31:24];

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: if (w_room && w_more) w_next = S_REQ;
            S_REQ:  if (wb_ack) w_next = w_last ? S_DONE : S_IDLE;
            S_DONE: w_next = S_DONE;
            default: w_next = S_IDLE;
        endcase
        if (frame_start) w_next = S_IDLE;
    end

    always_ff @(posedge pixel_clk or posedge pixel_rst) begin
        if (pixel_rst) begin
            r_state <= S_IDLE;
            r_index <= '0;
            r_adr   <= BASE_ADDR;
        end else begin
            r_state <= w_next;
            if (frame_start)
                r_index <= '0;
            else if (w_push)
                r_index <= r_index + IW'(1);
            if (w_issue)
                r_adr <= BASE_ADDR + (32'(r_index) << 2);
        end
    end

    always_ff @(posedge pixel_clk) begin
        if (w_push)
            r_mem[r_wptr] <= wb_dat_i[23:0];
    end

    always_ff @(posedge pixel_clk or posedge pixel_rst) begin
        if (pixel_rst) begin
            r_wptr      <= '0;
            r_rptr      <= '0;
            r_level     <= '0;
            r_rgb       <= '0;
            r_underflow <= 1'b0;
        end else if (frame_start) begin
            r_wptr      <= '0;
            r_rptr      <= '0;
            r_level     <= '0;
            r_underflow <= 1'b0;
            if (pixel_req)
                r_rgb <= '0;
        end else begin
            if (w_push)
                r_wptr <= r_wptr + AW'(1);
            if (w_pop)
                r_rptr <= r_rptr + AW'(1);
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + LW'(1);
                2'b01:   r_level <= r_level - LW'(1);
                default: r_level <= r_level;
            endcase
            if (pixel_req) begin
                if (r_level != '0) begin
                    r_rgb <= r_mem[r_rptr];
                end else begin
                    r_rgb       <= '0;
                    r_underflow <= 1'b1;
                end
            end
        end
    end

    assign wb_cyc     = (r_state == S_REQ);
    assign wb_stb     = (r_state == S_REQ);
    assign wb_adr     = r_adr;
    assign pixel_rgb  = r_rgb;
    assign underflow  = r_underflow;
    assign fifo_level = r_level;

endmodule

// File: tb/tb_vga_pixel_fetch.sv
// Directed bench for vga_pixel_fetch: a default-size instance and a tiny
// 4x2 frame / 4-entry FIFO instance, each served by a simple Wishbone slave.
module tb_vga_pixel_fetch;

    logic        clk;
    logic        rst;

    logic        fs_b, req_b, ack_b;
    logic [31:0] dat_b;
    logic        cyc_b, stb_b, uf_b;
    logic [31:0] adr_b;
    logic [23:0] rgb_b;
    logic [8:0]  lvl_b;

    logic        fs_s, req_s, ack_s;
    logic [31:0] dat_s;
    logic        cyc_s, stb_s, uf_s;
    logic [31:0] adr_s;
    logic [23:0] rgb_s;
    logic [2:0]  lvl_s;

    int n_run  = 0;
    int n_fail = 0;

    logic mode_b = 1'b0, seen_b = 1'b0, sack_b = 1'b0;
    logic mode_s = 1'b0, seen_s = 1'b0, sack_s = 1'b0;
    logic [31:0] q_b[$];
    logic [31:0] q_s[$];
    logic [23:0] px_s[$];

    vga_pixel_fetch u_big (
        .pixel_clk(clk), .pixel_rst(rst), .frame_start(fs_b), .pixel_req(req_b),
        .pixel_rgb(rgb_b), .underflow(uf_b), .wb_cyc(cyc_b), .wb_stb(stb_b),
        .wb_adr(adr_b), .wb_dat_i(dat_b), .wb_ack(ack_b), .fifo_level(lvl_b)
    );

    vga_pixel_fetch #(
        .HDISP(4), .VDISP(2), .FIFO_DEPTH(4), .BASE_ADDR(32'h0000_1000)
    ) u_small (
        .pixel_clk(clk), .pixel_rst(rst), .frame_start(fs_s), .pixel_req(req_s),
        .pixel_rgb(rgb_s), .underflow(uf_s), .wb_cyc(cyc_s), .wb_stb(stb_s),
        .wb_adr(adr_s), .wb_dat_i(dat_s), .wb_ack(ack_s), .fifo_level(lvl_s)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_run++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one cycle; slave acks the second cycle a strobe is seen and
    // returns {EE, C3, adr[17:2]}; cycle after a slave ack must have stb low.
    task automatic tick();
        logic gb, gs;
        @(posedge clk); #1;
        gb = sack_b; gs = sack_s;
        sack_b = 1'b0; sack_s = 1'b0; ack_b = 1'b0; ack_s = 1'b0;
        if (gb) chk("ack_gap_b", 32'(stb_b), 32'd0);
        else if (mode_b && stb_b) begin
            if (seen_b) begin
                ack_b = 1'b1; sack_b = 1'b1; seen_b = 1'b0;
                dat_b = {8'hEE, 8'hC3, adr_b[17:2]};
                q_b.push_back(adr_b);
            end else seen_b = 1'b1;
        end
        if (gs) chk("ack_gap_s", 32'(stb_s), 32'd0);
        else if (mode_s && stb_s) begin
            if (seen_s) begin
                ack_s = 1'b1; sack_s = 1'b1; seen_s = 1'b0;
                dat_s = {8'hEE, 8'hC3, adr_s[17:2]};
                q_s.push_back(adr_s);
            end else seen_s = 1'b1;
        end
    endtask

    initial begin
        int n, bad;
        logic anyc;
        logic [23:0] last;

        rst = 1'b1;
        fs_b = 0; req_b = 0; ack_b = 0; dat_b = '0;
        fs_s = 0; req_s = 0; ack_s = 0; dat_s = '0;
        repeat (3) tick();

        // reset state
        chk("rst_cyc_b", 32'(cyc_b), 32'd0);
        chk("rst_stb_b", 32'(stb_b), 32'd0);
        chk("rst_adr_b", adr_b, 32'h0);
        chk("rst_rgb_b", 32'(rgb_b), 32'd0);
        chk("rst_uf_b",  32'(uf_b), 32'd0);
        chk("rst_lvl_b", 32'(lvl_b), 32'd0);
        chk("rst_adr_s", adr_s, 32'h1000);

        // fill from reset release, no frame_start needed
        rst = 1'b0; mode_b = 1'b1;
        n = 0;
        while (lvl_b != 9'd256 && n < 2000) begin tick(); n++; end
        chk("fill_lvl", 32'(lvl_b), 32'd256);
        chk("fill_reads", 32'(q_b.size()), 32'd256);
        bad = 0;
        foreach (q_b[i]) if (q_b[i] != 32'(i) * 4) bad++;
        chk("fill_order", 32'(bad), 32'd0);
        chk("fill_last_adr", q_b[255], 32'h3FC);
        anyc = 1'b0;
        repeat (10) begin tick(); anyc |= cyc_b; end
        chk("full_no_cyc", 32'(anyc), 32'd0);
        chk("small_cyc", 32'(cyc_s), 32'd1);
        chk("small_adr", adr_s, 32'h1000);

        // one pop from full FIFO, then the next read issues
        req_b = 1'b1; tick(); req_b = 1'b0;
        chk("pop_rgb", 32'(rgb_b), 32'h00C30000);
        chk("pop_lvl", 32'(lvl_b), 32'd255);
        tick();
        chk("refetch_cyc", 32'(cyc_b), 32'd1);
        chk("refetch_adr", adr_b, 32'h400);
        n = 0;
        while (lvl_b != 9'd256 && n < 20) begin tick(); n++; end
        chk("refill_lvl", 32'(lvl_b), 32'd256);
        repeat (3) tick();
        chk("rgb_hold", 32'(rgb_b), 32'h00C30000);
        req_b = 1'b1;
        tick(); chk("pop_seq1", 32'(rgb_b), 32'h00C30001);
        tick(); chk("pop_seq2", 32'(rgb_b), 32'h00C30002);
        tick(); chk("pop_seq3", 32'(rgb_b), 32'h00C30003);
        req_b = 1'b0;

        // flush, underflow, then frame_start colliding with ack of index 5 and a pop
        fs_b = 1'b1; tick(); fs_b = 1'b0; seen_b = 1'b0; q_b.delete();
        chk("fs_lvl_b", 32'(lvl_b), 32'd0);
        req_b = 1'b1; tick(); req_b = 1'b0;
        chk("uf_b_set", 32'(uf_b), 32'd1);
        chk("uf_b_rgb", 32'(rgb_b), 32'd0);
        n = 0;
        while (lvl_b < 9'd2 && n < 40) begin tick(); n++; end
        req_b = 1'b1; tick(); req_b = 1'b0;
        chk("pop_after_fs", 32'(rgb_b), 32'h00C30000);
        chk("uf_b_sticky", 32'(uf_b), 32'd1);
        n = 0;
        while (!(ack_b && adr_b == 32'h14) && n < 100) begin tick(); n++; end
        chk("ack5_seen", 32'(ack_b), 32'd1);
        fs_b = 1'b1; req_b = 1'b1; tick(); fs_b = 1'b0; req_b = 1'b0; seen_b = 1'b0;
        chk("fsack_lvl", 32'(lvl_b), 32'd0);
        chk("fsack_cyc", 32'(cyc_b), 32'd0);
        chk("fsack_rgb", 32'(rgb_b), 32'd0);
        chk("fsack_uf",  32'(uf_b), 32'd0);
        mode_b = 1'b0;
        tick();
        chk("fsack_cyc2", 32'(cyc_b), 32'd1);
        chk("fsack_adr", adr_b, 32'h0);

        // tiny frame, continuous pops: 8 reads then DONE
        fs_s = 1'b1; tick(); fs_s = 1'b0; seen_s = 1'b0; q_s.delete();
        mode_s = 1'b1; req_s = 1'b1; last = '0;
        repeat (60) begin
            tick();
            if (rgb_s != 24'h0 && rgb_s != last) px_s.push_back(rgb_s);
            last = rgb_s;
        end
        req_s = 1'b0;
        chk("tiny_reads", 32'(q_s.size()), 32'd8);
        bad = 0;
        foreach (q_s[i]) if (q_s[i] != 32'h1000 + 32'(i) * 4) bad++;
        chk("tiny_order", 32'(bad), 32'd0);
        chk("tiny_last_adr", q_s[q_s.size() - 1], 32'h101C);
        chk("tiny_pix_cnt", 32'(px_s.size()), 32'd8);
        chk("tiny_pix_last", 32'(px_s[px_s.size() - 1]), 32'h00C30407);
        anyc = 1'b0;
        repeat (10) begin tick(); anyc |= cyc_s; end
        chk("done_no_cyc", 32'(anyc), 32'd0);
        q_s.delete();
        fs_s = 1'b1; tick(); fs_s = 1'b0; seen_s = 1'b0;
        chk("done_fs_cyc", 32'(cyc_s), 32'd0);
        chk("done_fs_uf",  32'(uf_s), 32'd0);
        tick();
        chk("restart_cyc", 32'(cyc_s), 32'd1);
        chk("restart_adr", adr_s, 32'h1000);

        // push and pop together at level 3, across pointer wrap
        n = 0;
        while (lvl_s != 3'd4 && n < 40) begin tick(); n++; end
        chk("tiny_full", 32'(lvl_s), 32'd4);
        req_s = 1'b1; tick(); req_s = 1'b0;
        chk("wrap_pop0", 32'(rgb_s), 32'h00C30400);
        chk("wrap_lvl3", 32'(lvl_s), 32'd3);
        n = 0;
        while (!ack_s && n < 10) begin tick(); n++; end
        chk("wrap_ack", 32'(ack_s), 32'd1);
        req_s = 1'b1; mode_s = 1'b0; tick(); req_s = 1'b0;
        chk("pushpop_lvl", 32'(lvl_s), 32'd3);
        chk("pushpop_rgb", 32'(rgb_s), 32'h00C30401);
        req_s = 1'b1;
        tick(); chk("wrap_pop2", 32'(rgb_s), 32'h00C30402);
        tick(); chk("wrap_pop3", 32'(rgb_s), 32'h00C30403);
        tick(); chk("wrap_pop4", 32'(rgb_s), 32'h00C30404);
        req_s = 1'b0;
        chk("wrap_lvl0", 32'(lvl_s), 32'd0);

        // underflow with slave never acking
        req_s = 1'b1; tick(); req_s = 1'b0;
        chk("uf_rgb", 32'(rgb_s), 32'd0);
        chk("uf_set", 32'(uf_s), 32'd1);
        repeat (4) tick();
        chk("uf_sticky", 32'(uf_s), 32'd1);
        fs_s = 1'b1; tick(); fs_s = 1'b0;
        chk("uf_clear", 32'(uf_s), 32'd0);

        // reset mid-read drops the strobe at once; a later ack is ignored
        tick();
        chk("mid_cyc", 32'(cyc_s), 32'd1);
        #3 rst = 1'b1;
        #1;
        chk("async_cyc", 32'(cyc_s), 32'd0);
        chk("async_stb", 32'(stb_s), 32'd0);
        tick();
        rst = 1'b0; ack_s = 1'b1; dat_s = 32'hEEFFFFFF;
        tick();
        chk("late_ack_lvl", 32'(lvl_s), 32'd0);
        chk("post_rst_cyc", 32'(cyc_s), 32'd1);
        chk("post_rst_adr", adr_s, 32'h1000);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule

// File: doc/vga_pixel_fetch.md
VGA_PIXEL_FETCH -- requirements
Module: vga_pixel_fetch

Interface
REQ-001 Parameter HDISP, default 800, active pixels per line.
REQ-002 Parameter VDISP, default 480, active lines per frame.
REQ-003 Parameter FIFO_DEPTH, default 256, pixel FIFO entries, power of two >= 4.
REQ-004 Parameter BASE_ADDR, default 32'h0000_0000, byte address of framebuffer pixel (0,0), 4-byte aligned.
REQ-005 pixel_clk  input  1  sole clock; all logic on rising edge.
REQ-006 pixel_rst  input  1  reset, asynchronous, active-high.
REQ-007 frame_start  input  1  one-cycle pulse at start of vertical sync, from the timing generator.
REQ-008 pixel_req  input  1  high for each displayed pixel (not BLANK) from the timing generator.
REQ-009 pixel_rgb  output  24  pixel to video_if RGB; {R[23:16],G[15:8],B[7:0]}.
REQ-010 underflow  output  1  sticky: pixel_req arrived with FIFO empty.
REQ-011 wb_cyc  output  1  Wishbone classic cycle.
REQ-012 wb_stb  output  1  Wishbone strobe.
REQ-013 wb_adr  output  32  Wishbone byte address.
REQ-014 wb_dat_i  input  32  read data; bits [23:0] are RGB, [31:24] ignored.
REQ-015 wb_ack  input  1  read acknowledge.
REQ-016 fifo_level  output  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.

Function
REQ-017 Block SHALL read the frame linearly, one pixel per 32-bit word, index 0..HDISP*VDISP-1, wb_adr = BASE_ADDR + 4*index.
REQ-018 Fetch FSM SHALL have states IDLE, REQ, DONE.
REQ-019 IDLE->REQ when fifo_level < FIFO_DEPTH and index < HDISP*VDISP; wb_cyc=wb_stb=1 and wb_adr registered on entry.
REQ-020 In REQ, wb_cyc/wb_stb/wb_adr SHALL stay stable until wb_ack; single outstanding read, no pipelining.
REQ-021 On wb_ack in REQ: wb_dat_i[23:0] pushed to FIFO same edge, index incremented, cyc/stb dropped; next state DONE if index was HDISP*VDISP-1, else IDLE.
REQ-022 A new request SHALL NOT issue in the cycle following an ack (cyc/stb low at least one cycle between reads).
REQ-023 DONE SHALL hold cyc/stb low until frame_start.
REQ-024 frame_start in any state: next cycle cyc/stb=0, index=0, FIFO flushed (level 0), underflow cleared, FSM=IDLE; a wb_ack in that same cycle SHALL be discarded.
REQ-025 Pop: pixel_req with level>0 SHALL register FIFO head onto pixel_rgb next edge (latency 1 cycle) and decrement level.
REQ-026 pixel_req with level=0 SHALL drive pixel_rgb=24'h0 next edge and set underflow.
REQ-027 pixel_rgb SHALL hold its last value while pixel_req=0.
REQ-028 Simultaneous push and pop SHALL leave level unchanged; push never occurs at level=FIFO_DEPTH (guaranteed by REQ-019, no outstanding read counts extra).
REQ-029 frame_start coincident with pixel_req: flush wins, pixel_rgb=0, underflow stays cleared.
REQ-030 FIFO pointers SHALL wrap modulo FIFO_DEPTH; level ranges 0..FIFO_DEPTH.

Reset
REQ-031 On pixel_rst: wb_cyc=0, wb_stb=0, wb_adr=BASE_ADDR, pixel_rgb=0, underflow=0, fifo_level=0, index=0, FSM=IDLE.
REQ-032 After reset release, fetching SHALL begin without waiting for frame_start.
REQ-033 Reset asserted mid-read SHALL drop cyc/stb immediately (asynchronously); a later wb_ack SHALL be ignored.

Verification
REQ-034 Reset release, slave acks 1 cycle after stb: FIFO fills to 256 with addresses 0x0,0x4,...,0x3FC, then cyc stays 0.
REQ-035 Full FIFO, pixel_req pulsed 1 cycle: pixel_rgb = word at 0x0 next edge, level 255, then read of 0x400 issues.
REQ-036 Empty FIFO (slave never acks), pixel_req=1: pixel_rgb=0, underflow=1, stays 1 until frame_start.
REQ-037 HDISP=4, VDISP=2, FIFO_DEPTH=4, continuous pops: exactly 8 reads, addresses 0x0..0x1C, FSM DONE, no read until frame_start, then restart at 0x0.
REQ-038 frame_start same cycle as wb_ack for index 5: data not pushed, level 0, next read address BASE_ADDR.
REQ-039 Push and pop same cycle at level 3: level stays 3, pixel order preserved across pointer wrap.
